// File: rtl/io_port_arbiter_pkg.sv
// Shared definitions for the I/O port arbiter: parameter defaults and FSM state encoding.
package io_port_arbiter_pkg;

  localparam int unsigned DefNReq    = 4;
  localparam int unsigned DefAddrW   = 3;
  localparam int unsigned DefDataW   = 8;
  localparam int unsigned DefTimeout = 15;

  // Wide enough for any timeout in 1..255.
  localparam int unsigned CntW = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

endpackage

// File: rtl/io_port_arbiter_if.sv
// Requester-side handshake plus port-bank signals of the I/O port arbiter.
interface io_port_arbiter_if
  import io_port_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ  = DefNReq,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
);

  logic [N_REQ-1:0]          req;
  logic [N_REQ-1:0]          wr;
  logic [N_REQ*ADDR_W-1:0]   addr;
  logic [N_REQ*DATA_W-1:0]   wdata;
  logic [N_REQ-1:0]          gnt;
  logic [N_REQ-1:0]          ack;
  logic                      err;
  logic [DATA_W-1:0]         rdata;
  logic [(1<<ADDR_W)-1:0]    io_ena;
  logic                      io_we;
  logic [DATA_W-1:0]         io_wdata;
  logic [DATA_W-1:0]         io_rdata;
  logic                      io_ready;

  // Masters and the port bank drive requests and port responses.
  modport master (
    output req, wr, addr, wdata, io_rdata, io_ready,
    input  gnt, ack, err, rdata, io_ena, io_we, io_wdata
  );

  modport slave (
    input  req, wr, addr, wdata, io_rdata, io_ready,
    output gnt, ack, err, rdata, io_ena, io_we, io_wdata
  );

endinterface

// File: rtl/io_port_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after rr_ptr, wrapping modulo N_REQ.
module io_port_arbiter_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [IDX_W-1:0] win_idx
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % int'(N_REQ));
      if (!found && req[cand]) begin
        found         = 1'b1;
        win_idx       = cand;
        win_oh[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_port_arbiter.sv
// Round-robin arbiter sharing an 8-port I/O bank among N_REQ masters, one byte per transaction,
// with a ready timeout that completes the access with err and all-ones read data.
module io_port_arbiter
  import io_port_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ   = DefNReq,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input logic             clk,
  input logic             rst,
  io_port_arbiter_if.slave bus
);

  localparam int unsigned IdxW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned NPort = 1 << ADDR_W;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [IdxW-1:0]     own_q, own_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [NPort-1:0]    io_ena_q, io_ena_d;
  logic                io_we_q, io_we_d;
  logic [DATA_W-1:0]   io_wdata_q, io_wdata_d;

  logic [N_REQ-1:0]    pick_oh;
  logic [IdxW-1:0]     pick_idx;
  logic [ADDR_W-1:0]   addr_sel;

  io_port_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IdxW)
  ) u_rr_pick (
    .req     (bus.req),
    .rr_ptr  (ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx)
  );

  assign addr_sel = bus.addr[pick_idx*ADDR_W +: ADDR_W];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    own_d      = own_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    ack_d      = '0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    io_ena_d   = io_ena_q;
    io_we_d    = io_we_q;
    io_wdata_d = io_wdata_q;
    unique case (state_q)
      StIdle: begin
        gnt_d = '0;
        if (|bus.req) begin
          // The port strobes are set up here so they are valid from the first ACCESS cycle.
          gnt_d            = pick_oh;
          own_d            = pick_idx;
          io_ena_d         = '0;
          io_ena_d[addr_sel] = 1'b1;
          io_we_d          = bus.wr[pick_idx];
          io_wdata_d       = bus.wdata[pick_idx*DATA_W +: DATA_W];
          cnt_d            = '0;
          state_d          = StAccess;
        end
      end
      StAccess: begin
        if (bus.io_ready || (cnt_q == CntLast)) begin
          // Ready wins over a timeout landing on the same cycle.
          rdata_d  = bus.io_ready ? (io_we_q ? '0 : bus.io_rdata) : '1;
          err_d    = !bus.io_ready;
          ack_d    = gnt_q;
          io_ena_d = '0;
          io_we_d  = 1'b0;
          state_d  = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        gnt_d   = '0;
        ptr_d   = own_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= IdxW'(N_REQ - 1);
      own_q      <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      io_ena_q   <= '0;
      io_we_q    <= 1'b0;
      io_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      own_q      <= own_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      io_ena_q   <= io_ena_d;
      io_we_q    <= io_we_d;
      io_wdata_q <= io_wdata_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.rdata    = rdata_q;
  assign bus.io_ena   = io_ena_q;
  assign bus.io_we    = io_we_q;
  assign bus.io_wdata = io_wdata_q;

endmodule

// File: tb/tb_io_port_arbiter.sv
// Self-checking bench for io_port_arbiter: reset cases, a directed vector table, round-robin
// sequences and randomized transactions checked against a transaction-level model.
module tb_io_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int TO = 15;

  logic clk;
  logic rst;

  io_port_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  io_port_arbiter #(
    .N_REQ   (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic           wr_a   [N];
  logic [AW-1:0]  addr_a [N];
  logic [DW-1:0]  wd_a   [N];

  typedef struct {
    logic [N-1:0] req;
    logic         wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int           ready_at;
    logic [DW-1:0] rd;
    int           drop_at;
    logic [N-1:0] e_oh;
    logic [7:0]   e_ena;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      bus.wr[i]              = wr_a[i];
      bus.addr[i*AW +: AW]   = addr_a[i];
      bus.wdata[i*DW +: DW]  = wd_a[i];
    end
  endtask

  task automatic scramble();
    for (int i = 0; i < N; i++) begin
      wr_a[i]   = 1'($urandom);
      addr_a[i] = AW'($urandom);
      wd_a[i]   = DW'($urandom);
    end
    pack();
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_a[i]   = w;
    addr_a[i] = a;
    wd_a[i]   = d;
    pack();
  endtask

  // Round-robin rule: first requester after the last winner, wrapping.
  function automatic int model_pick(input logic [N-1:0] m, input int rr);
    for (int k = 1; k <= N; k++)
      if (m[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  // Called at a negedge with req already applied; returns at the negedge of the IDLE cycle
  // following the ack.
  task automatic do_txn(input string tag, input logic [N-1:0] e_oh, input logic [7:0] e_ena,
                        input logic e_we, input logic [DW-1:0] e_wd, input int ready_at,
                        input logic [DW-1:0] rd, input int drop_at);
    int   c;
    bit   done;
    int   e_n;
    logic e_err;
    logic [DW-1:0] e_rd;
    e_err = !(ready_at >= 1 && ready_at <= TO);
    e_n   = e_err ? TO : ready_at;
    e_rd  = e_err ? 8'hFF : (e_we ? 8'h00 : rd);
    bus.io_rdata = rd;
    c    = 0;
    done = 0;
    @(posedge clk);
    while (!done) begin
      @(negedge clk);
      c++;
      if (bus.ack != '0) begin
        check({tag, ".ack"},   32'(bus.ack),   32'(e_oh));
        check({tag, ".err"},   32'(bus.err),   32'(e_err));
        check({tag, ".rdata"}, 32'(bus.rdata), 32'(e_rd));
        check({tag, ".gnt_resp"}, 32'({bus.gnt, bus.io_ena, bus.io_we}), 32'({e_oh, 8'h00, 1'b0}));
        check({tag, ".latency"}, 32'(c - 1), 32'(e_n));
        done = 1;
      end else if (c > TO + 3) begin
        n_chk++;
        n_err++;
        $display("FAIL %s.ack_wait: got no ack after %0d cycles, want ack", tag, c);
        done = 1;
      end else begin
        check({tag, ".access"}, 32'({bus.gnt, bus.io_ena, bus.io_we, bus.io_wdata}),
              32'({e_oh, e_ena, e_we, e_wd}));
        if (c == drop_at) bus.req = bus.req & ~e_oh;
        scramble();
        bus.io_ready = (c == ready_at);
      end
    end
    bus.req      = bus.req & ~e_oh;
    bus.io_ready = 1'b0;
    @(negedge clk);
    check({tag, ".idle"}, 32'({bus.gnt, bus.ack, bus.err, bus.io_ena, bus.io_we}), 32'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    bus.req      = '0;
    bus.io_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int rr_m;
    logic [N-1:0] m;
    int ra;
    int da;
    logic [DW-1:0] rd;

    rst          = 1'b1;
    bus.req      = '0;
    bus.io_ready = 1'b0;
    bus.io_rdata = '0;
    scramble();

    // Reset values, then reset asserted in the middle of an ACCESS.
    do_reset();
    check("reset.ctl",  32'({bus.gnt, bus.ack, bus.err, bus.io_ena, bus.io_we}), 32'(0));
    check("reset.data", 32'({bus.rdata, bus.io_wdata}), 32'(0));
    set_req(1, 1'b1, 3'd5, 8'hA5);
    bus.req = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    check("rstA.access", 32'({bus.gnt, bus.io_ena, bus.io_we, bus.io_wdata}),
          32'({4'b0010, 8'h20, 1'b1, 8'hA5}));
    #2 rst = 1'b1;
    #1 check("rstA.async", 32'({bus.gnt, bus.ack, bus.io_ena, bus.io_we}), 32'(0));
    @(negedge clk);
    check("rstA.held", 32'({bus.gnt, bus.ack, bus.err}), 32'(0));
    rst     = 1'b0;
    bus.req = 4'b0011;
    set_req(0, 1'b0, 3'd0, 8'h00);
    do_txn("rstA.r0", 4'b0001, 8'h01, 1'b0, 8'h00, 1, 8'h42, 0);
    set_req(1, 1'b1, 3'd2, 8'h5E);
    do_txn("rstA.r1", 4'b0010, 8'h04, 1'b1, 8'h5E, 2, 8'h00, 0);

    // Directed table; the pointer starts at N-1 after reset and carries between rows.
    tbl[0] = '{4'b0001, 1'b1, 3'd3, 8'h3C, 1,  8'h00, 0, 4'b0001, 8'h08};
    tbl[1] = '{4'b0100, 1'b0, 3'd6, 8'h00, 4,  8'h5A, 0, 4'b0100, 8'h40};
    tbl[2] = '{4'b1000, 1'b0, 3'd1, 8'h00, 0,  8'h77, 0, 4'b1000, 8'h02};
    tbl[3] = '{4'b0010, 1'b1, 3'd0, 8'h99, 2,  8'h00, 0, 4'b0010, 8'h01};
    tbl[4] = '{4'b0010, 1'b0, 3'd7, 8'h00, 15, 8'hC3, 5, 4'b0010, 8'h80};
    tbl[5] = '{4'b0001, 1'b0, 3'd2, 8'h00, 16, 8'h3A, 0, 4'b0001, 8'h04};
    tbl[6] = '{4'b0110, 1'b0, 3'd4, 8'h00, 1,  8'h11, 0, 4'b0010, 8'h10};
    tbl[7] = '{4'b0100, 1'b1, 3'd5, 8'hE7, 3,  8'h00, 0, 4'b0100, 8'h20};
    tbl[8] = '{4'b1001, 1'b0, 3'd0, 8'h00, 2,  8'h81, 0, 4'b1000, 8'h01};
    tbl[9] = '{4'b0011, 1'b1, 3'd7, 8'hF0, 1,  8'h00, 0, 4'b0001, 8'h80};
    do_reset();
    for (int v = 0; v < 10; v++) begin
      scramble();
      w = 0;
      for (int i = 0; i < N; i++) if (tbl[v].e_oh[i]) w = i;
      set_req(w, tbl[v].wr, tbl[v].addr, tbl[v].wd);
      bus.req = tbl[v].req;
      do_txn($sformatf("tbl%0d", v), tbl[v].e_oh, tbl[v].e_ena, tbl[v].wr, tbl[v].wd,
             tbl[v].ready_at, tbl[v].rd, tbl[v].drop_at);
    end

    // All four requesting: served 0,1,2,3; then 0 and 3 with the pointer at 3.
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < N; i++) begin
      set_req(i, 1'(i % 2), AW'(i + 1), DW'(8'h10 + i));
      do_txn($sformatf("rr%0d", i), N'(1 << i), 8'(1 << (i + 1)), 1'(i % 2), DW'(8'h10 + i),
             1 + i, 8'h60, 0);
    end
    bus.req = 4'b1001;
    set_req(0, 1'b0, 3'd6, 8'h00);
    do_txn("rr_wrap0", 4'b0001, 8'h40, 1'b0, 8'h00, 1, 8'hB4, 0);
    set_req(3, 1'b1, 3'd2, 8'hD2);
    do_txn("rr_wrap3", 4'b1000, 8'h04, 1'b1, 8'hD2, 1, 8'h00, 0);

    // Randomized transactions against the model.
    do_reset();
    rr_m = N - 1;
    for (int t = 0; t < 60; t++) begin
      m  = N'($urandom_range(1, (1 << N) - 1));
      ra = $urandom_range(0, TO + 2);
      da = $urandom_range(0, 20);
      rd = DW'($urandom);
      scramble();
      w = model_pick(m, rr_m);
      bus.req = m;
      do_txn($sformatf("rand%0d", t), N'(1 << w), 8'(1 << addr_a[w]), wr_a[w], wd_a[w],
             ra, rd, da);
      rr_m = w;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
